// File: rtl/tile_fetch_agu_if.sv
// Control, configuration and BRAM-side signal bundle for the tile fetch address-generation unit.
// The master side (fetch controller) issues start/abort/config and back-pressure;
// the slave side (tile_fetch_agu) returns the BRAM read strobes and status.
interface tile_fetch_agu_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int LEN_WIDTH  = 10,
    parameter int TILE_WIDTH = 9
);
    logic                  start;
    logic                  abort;
    logic [ADDR_WIDTH-1:0] cfg_base;
    logic [LEN_WIDTH-1:0]  cfg_len;
    logic [TILE_WIDTH-1:0] cfg_tiles;
    logic                  cfg_transpose;
    logic [ADDR_WIDTH-1:0] cfg_stride;
    logic                  out_ready;
    logic [ADDR_WIDTH-1:0] bram_addr;
    logic                  bram_en;
    logic                  rd_valid;
    logic                  rd_last;
    logic                  tile_done;
    logic                  busy;
    logic                  done;

    modport master (
        output start, abort, cfg_base, cfg_len, cfg_tiles, cfg_transpose, cfg_stride, out_ready,
        input  bram_addr, bram_en, rd_valid, rd_last, tile_done, busy, done
    );

    modport slave (
        input  start, abort, cfg_base, cfg_len, cfg_tiles, cfg_transpose, cfg_stride, out_ready,
        output bram_addr, bram_en, rd_valid, rd_last, tile_done, busy, done
    );
endinterface

// File: rtl/tile_fetch_agu.sv
// Tile fetch address-generation unit: one start walks cfg_tiles tiles of cfg_len reads each,
// in linear (base + t*len + k) or transposed (base + t + k*stride) order, using running
// accumulators only. Read strobes are delayed by RD_LATENCY so rd_valid/rd_last line up
// with the BRAM data. Abort cancels a run and flushes the in-flight strobes.
module tile_fetch_agu #(
    parameter int ADDR_WIDTH = 16,
    parameter int LEN_WIDTH  = 10,
    parameter int TILE_WIDTH = 9,
    parameter int RD_LATENCY = 2
) (
    input logic           clk,
    input logic           rst_n,
    tile_fetch_agu_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // All pipeline stages except the output stage; DRAIN ends once these are empty.
    localparam logic [RD_LATENCY-1:0] EARLY_MASK =
        RD_LATENCY'((64'd1 << (RD_LATENCY - 1)) - 64'd1);

    state_t                state;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [TILE_WIDTH-1:0] tiles_q;
    logic                  transpose_q;
    logic [ADDR_WIDTH-1:0] stride_q;
    logic [LEN_WIDTH-1:0]  k_q;
    logic [TILE_WIDTH-1:0] t_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] tile_addr_q;
    logic [RD_LATENCY-1:0] pipe_valid;
    logic [RD_LATENCY-1:0] pipe_last;

    logic                  abort_hit;
    logic                  issue;
    logic                  last_k;
    logic                  last_t;
    logic [ADDR_WIDTH-1:0] elem_step;
    logic [ADDR_WIDTH-1:0] tile_step;
    logic [ADDR_WIDTH-1:0] next_tile_addr;

    // Abort only matters while a run is active; in IDLE it merely masks start.
    assign abort_hit = bus.abort && (state != IDLE);
    // A read issues whenever FETCH sees a ready consumer and no abort this cycle.
    assign issue     = (state == FETCH) && bus.out_ready && !bus.abort;
    assign last_k    = (k_q == len_q - LEN_WIDTH'(1));
    assign last_t    = (t_q == tiles_q - TILE_WIDTH'(1));

    // Linear: +1 within a tile, +len between tile starts. Transposed: +stride within, +1 between.
    assign elem_step      = transpose_q ? stride_q : ADDR_WIDTH'(1);
    assign tile_step      = transpose_q ? ADDR_WIDTH'(1) : ADDR_WIDTH'(len_q);
    assign next_tile_addr = tile_addr_q + tile_step;

    assign bus.bram_en   = issue;
    assign bus.bram_addr = (state == FETCH) ? addr_q : '0;
    assign bus.rd_valid  = pipe_valid[RD_LATENCY-1] && !abort_hit;
    assign bus.rd_last   = pipe_last[RD_LATENCY-1] && !abort_hit;
    assign bus.tile_done = bus.rd_valid && bus.rd_last;
    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == DONE) && !bus.abort;

    // Run controller: config capture, tile/element counters and address accumulators.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            state       <= IDLE;
            len_q       <= '0;
            tiles_q     <= '0;
            transpose_q <= 1'b0;
            stride_q    <= '0;
            k_q         <= '0;
            t_q         <= '0;
            addr_q      <= '0;
            tile_addr_q <= '0;
        end else if (abort_hit) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start && !bus.abort) begin
                        len_q       <= bus.cfg_len;
                        tiles_q     <= bus.cfg_tiles;
                        transpose_q <= bus.cfg_transpose;
                        stride_q    <= bus.cfg_stride;
                        k_q         <= '0;
                        t_q         <= '0;
                        addr_q      <= bus.cfg_base;
                        tile_addr_q <= bus.cfg_base;
                        state       <= (bus.cfg_len == '0 || bus.cfg_tiles == '0) ? DONE : FETCH;
                    end
                end
                FETCH: begin
                    if (issue) begin
                        if (last_k) begin
                            k_q <= '0;
                            if (last_t) begin
                                state <= DRAIN;
                            end else begin
                                t_q         <= t_q + TILE_WIDTH'(1);
                                tile_addr_q <= next_tile_addr;
                                addr_q      <= next_tile_addr;
                            end
                        end else begin
                            k_q    <= k_q + LEN_WIDTH'(1);
                            addr_q <= addr_q + elem_step;
                        end
                    end
                end
                DRAIN: begin
                    if ((pipe_valid & EARLY_MASK) == '0) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                // NOTE: a default arm keeps an illegal encoding from wedging the FSM and avoids latch-like holds.
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Read-latency shift pipeline carrying the issue strobe and its last-of-tile flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: these are a handful of flops, not a RAM, so clearing them in reset is cheap and required.
            pipe_valid <= '0;
            pipe_last  <= '0;
        end else if (abort_hit) begin
            pipe_valid <= '0;
            pipe_last  <= '0;
        end else begin
            pipe_valid[0] <= issue;
            pipe_last[0]  <= issue && last_k;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_last[i]  <= pipe_last[i-1];
            end
        end
    end

endmodule
